// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the asynchronous FIFO (read and write sides).
package fifo_pkg;

  // Widest pointer the helpers handle; callers zero-extend and truncate.
  localparam int unsigned GC_W = 16;

  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [GC_W-1:0] bin2gray(input logic [GC_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits leave the result intact.
  function automatic logic [GC_W-1:0] gray2bin(input logic [GC_W-1:0] g);
    logic [GC_W-1:0] b;
    b = g;
    for (int unsigned i = 1; i < GC_W; i++) begin
      b[GC_W-1-i] = b[GC_W-i] ^ g[GC_W-1-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO control bus: request, incoming write pointer and status.
interface fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3
);
  localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);

  logic                  R_INC;
  logic [PTR_W-1:0]      WR_GRAY_PTR;
  logic [ADDR_WIDTH-1:0] R_ADDR;
  logic [PTR_W-1:0]      r_gray_out;
  logic                  EMPTY;
  logic                  ALMOST_EMPTY;
  logic [PTR_W-1:0]      RD_LEVEL;
  logic                  UNDERFLOW;

  modport master (
    output R_INC, WR_GRAY_PTR,
    input  R_ADDR, r_gray_out, EMPTY, ALMOST_EMPTY, RD_LEVEL, UNDERFLOW
  );

  modport slave (
    input  R_INC, WR_GRAY_PTR,
    output R_ADDR, r_gray_out, EMPTY, ALMOST_EMPTY, RD_LEVEL, UNDERFLOW
  );
endinterface

// File: rtl/fifo_gray_sync.sv
// Plain flop-chain synchroniser for a Gray-coded pointer crossing clock domains.
module fifo_gray_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift the pointer through the chain; no logic between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side control of the asynchronous FIFO: read pointer, empty/level/underflow.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 3,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input logic           R_CLK,
  input logic           R_RST,
  fifo_rd_ctrl_if.slave bus
);

  localparam int unsigned      PTR_W = ptr_width(ADDR_WIDTH);
  localparam logic [PTR_W-1:0] AE_TH = PTR_W'(AEMPTY_THRESH);

  function automatic logic [PTR_W-1:0] to_gray(input logic [PTR_W-1:0] b);
    return PTR_W'(bin2gray(GC_W'(b)));
  endfunction

  function automatic logic [PTR_W-1:0] to_bin(input logic [PTR_W-1:0] g);
    return PTR_W'(gray2bin(GC_W'(g)));
  endfunction

  logic [PTR_W-1:0] wq_sync;
  logic [PTR_W-1:0] wq_bin;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_ptr_nxt;
  logic [PTR_W-1:0] r_gray;
  logic [PTR_W-1:0] level_nxt;
  logic [PTR_W-1:0] rd_level;
  logic             rd_en;
  logic             empty;
  logic             aempty;
  logic             underflow;

  fifo_gray_sync #(
    .WIDTH (PTR_W),
    .STAGES(SYNC_STAGES)
  ) u_wq_sync (
    .clk(R_CLK),
    .rst(R_RST),
    .d  (bus.WR_GRAY_PTR),
    .q  (wq_sync)
  );

  // Next pointer and next level; read and write-pointer arrival combine here.
  always_comb begin
    rd_en     = bus.R_INC & ~empty;
    r_ptr_nxt = r_ptr + {{(PTR_W-1){1'b0}}, rd_en};
    wq_bin    = to_bin(wq_sync);
    level_nxt = wq_bin - r_ptr_nxt;
  end

  // Register pointer, its Gray copy and all status flags on the same edge.
  always_ff @(posedge R_CLK or posedge R_RST) begin
    if (R_RST) begin
      r_ptr     <= '0;
      r_gray    <= '0;
      empty     <= 1'b1;
      aempty    <= 1'b1;
      rd_level  <= '0;
      underflow <= 1'b0;
    end else begin
      r_ptr     <= r_ptr_nxt;
      r_gray    <= to_gray(r_ptr_nxt);
      empty     <= (to_gray(r_ptr_nxt) == wq_sync);
      aempty    <= (level_nxt <= AE_TH);
      rd_level  <= level_nxt;
      underflow <= underflow | (bus.R_INC & empty);
    end
  end

  assign bus.R_ADDR       = r_ptr[ADDR_WIDTH-1:0];
  assign bus.r_gray_out   = r_gray;
  assign bus.EMPTY        = empty;
  assign bus.ALMOST_EMPTY = aempty;
  assign bus.RD_LEVEL     = rd_level;
  assign bus.UNDERFLOW    = underflow;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed scenarios plus randomized traffic vs. a count-based model.
module tb_fifo_rd_ctrl;

  localparam int AW     = 3;
  localparam int SS     = 2;
  localparam int AE     = 1;
  localparam int DEPTH  = 1 << AW;
  localparam int MODV   = 2 * DEPTH;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;

  fifo_rd_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_rd_ctrl #(
    .ADDR_WIDTH   (AW),
    .SYNC_STAGES  (SS),
    .AEMPTY_THRESH(AE)
  ) dut (
    .R_CLK(clk),
    .R_RST(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  // Count whose Gray code matches g, found by search.
  function automatic int count_of_gray(input int g);
    for (int v = 0; v < MODV; v++) begin
      if (gray_of(v) == g) return v;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: write pointer seen after a SS-deep delay, read count, level as difference.
  int m_pipe [SS];
  int m_rd    = 0;
  int m_level = 0;
  bit m_uf    = 0;

  initial begin
    for (int i = 0; i < SS; i++) m_pipe[i] = 0;
  end

  always @(posedge clk or posedge rst) begin
    int wq_cnt;
    int nrd;
    if (rst) begin
      for (int i = 0; i < SS; i++) m_pipe[i] <= 0;
      m_rd    <= 0;
      m_level <= 0;
      m_uf    <= 0;
    end else begin
      wq_cnt = count_of_gray(m_pipe[SS-1]);
      nrd    = (m_rd + ((bus.R_INC === 1'b1 && m_level != 0) ? 1 : 0)) % MODV;
      if (bus.R_INC === 1'b1 && m_level == 0) m_uf <= 1;
      m_rd    <= nrd;
      m_level <= (wq_cnt - nrd + MODV) % MODV;
      for (int i = SS - 1; i > 0; i--) m_pipe[i] <= m_pipe[i-1];
      m_pipe[0] <= int'(bus.WR_GRAY_PTR);
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("addr",   32'(bus.R_ADDR),       32'(m_rd % DEPTH));
      chk("gray",   32'(bus.r_gray_out),   32'(gray_of(m_rd)));
      chk("empty",  32'(bus.EMPTY),        32'(m_level == 0));
      chk("aempty", 32'(bus.ALMOST_EMPTY), 32'(m_level <= AE));
      chk("level",  32'(bus.RD_LEVEL),     32'(m_level));
      chk("uflow",  32'(bus.UNDERFLOW),    32'(m_uf));
    end
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int wr_cnt;
    int wprob;
    rst             = 1'b0;
    bus.R_INC       = 1'b0;
    bus.WR_GRAY_PTR = '0;

    // 1: asynchronous reset asserted mid-clock
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_addr",   32'(bus.R_ADDR), 32'd0);
    chk("rst_gray",   32'(bus.r_gray_out), 32'd0);
    chk("rst_empty",  32'(bus.EMPTY), 32'd1);
    chk("rst_aempty", 32'(bus.ALMOST_EMPTY), 32'd1);
    chk("rst_level",  32'(bus.RD_LEVEL), 32'd0);
    chk("rst_uflow",  32'(bus.UNDERFLOW), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // 2: single write pointer step, then a second
    bus.WR_GRAY_PTR = 4'b0001;
    edges(2);
    chk("t2_empty_e2", 32'(bus.EMPTY), 32'd1);
    edges(1);
    chk("t2_empty_e3", 32'(bus.EMPTY), 32'd0);
    chk("t2_level1",   32'(bus.RD_LEVEL), 32'd1);
    chk("t2_aempty1",  32'(bus.ALMOST_EMPTY), 32'd1);
    bus.WR_GRAY_PTR = 4'b0011;
    edges(3);
    chk("t2_level2",   32'(bus.RD_LEVEL), 32'd2);
    chk("t2_aempty2",  32'(bus.ALMOST_EMPTY), 32'd0);

    // 3: full occupancy, then drain
    bus.WR_GRAY_PTR = 4'b1100;
    edges(3);
    chk("t3_level8", 32'(bus.RD_LEVEL), 32'd8);
    chk("t3_empty0", 32'(bus.EMPTY), 32'd0);
    bus.R_INC = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("t3_addr_step", 32'(bus.R_ADDR), 32'(i));
      edges(1);
    end
    bus.R_INC = 1'b0;
    chk("t3_addr_wrap", 32'(bus.R_ADDR), 32'd0);
    chk("t3_gray",      32'(bus.r_gray_out), 32'b1100);
    chk("t3_empty",     32'(bus.EMPTY), 32'd1);
    chk("t3_level0",    32'(bus.RD_LEVEL), 32'd0);

    // 4: underflow is sticky
    bus.R_INC = 1'b1;
    edges(1);
    bus.R_INC = 1'b0;
    chk("t4_addr_hold", 32'(bus.R_ADDR), 32'd0);
    chk("t4_uflow",     32'(bus.UNDERFLOW), 32'd1);
    edges(2);
    chk("t4_uflow_hold", 32'(bus.UNDERFLOW), 32'd1);

    // 5: pointer wrap through 1111
    bus.WR_GRAY_PTR = 4'b1000;
    edges(3);
    chk("t5_level7", 32'(bus.RD_LEVEL), 32'd7);
    bus.R_INC = 1'b1;
    edges(7);
    bus.R_INC = 1'b0;
    chk("t5_gray15", 32'(bus.r_gray_out), 32'b1000);
    bus.WR_GRAY_PTR = 4'b0001;
    edges(3);
    chk("t5_level2", 32'(bus.RD_LEVEL), 32'd2);
    chk("t5_empty0", 32'(bus.EMPTY), 32'd0);
    bus.R_INC = 1'b1;
    edges(2);
    bus.R_INC = 1'b0;
    chk("t5_addr1", 32'(bus.R_ADDR), 32'd1);
    chk("t5_gray1", 32'(bus.r_gray_out), 32'b0001);
    chk("t5_empty", 32'(bus.EMPTY), 32'd1);

    // 6: reset mid-operation clears sync flops too
    bus.WR_GRAY_PTR = 4'b0101;
    edges(3);
    chk("t6_level5", 32'(bus.RD_LEVEL), 32'd5);
    @(posedge clk); #2;
    rst             = 1'b1;
    bus.WR_GRAY_PTR = 4'b0000;
    #1;
    chk("t6_addr",  32'(bus.R_ADDR), 32'd0);
    chk("t6_gray",  32'(bus.r_gray_out), 32'd0);
    chk("t6_empty", 32'(bus.EMPTY), 32'd1);
    chk("t6_level", 32'(bus.RD_LEVEL), 32'd0);
    chk("t6_uflow", 32'(bus.UNDERFLOW), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      edges(1);
      chk("t6_empty_hold", 32'(bus.EMPTY), 32'd1);
    end

    // Randomized traffic: single-step legal write pointer, random reads
    wr_cnt = 0;
    wprob  = 50;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc % 200 == 0) wprob = $urandom_range(10, 90);
      bus.R_INC = ($urandom_range(0, 99) < 50);
      if ((((wr_cnt - m_rd + MODV) % MODV) < DEPTH) && ($urandom_range(0, 99) < wprob)) begin
        wr_cnt = (wr_cnt + 1) % MODV;
      end
      bus.WR_GRAY_PTR = 4'(gray_of(wr_cnt));
    end
    @(negedge clk);
    bus.R_INC = 1'b0;
    edges(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
